bip_mc_cpu: RTL and testbench

Multi-cycle, parametrised successor to the BIP CPU core. It fetches from an asynchronous-read ROM and executes the BIP I instruction set plus JMP/BEQ/AND/OR/XOR. Data memory is accessed over a request/ready handshake, so wait-state RAMs or shared buses can sit behind it. Instantiated by the BIP top in place of the fixed-latency core.

---
 rtl/bip_pkg.sv | 23 ++
 rtl/bip_mc_cpu_if.sv | 23 ++
 rtl/bip_alu.sv | 17 +
 rtl/bip_mc_cpu.sv | 109 ++++++++++
 tb/tb_bip_mc_cpu.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, FSM state encoding and decode helpers for the BIP multi-cycle core
package bip_pkg;
  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_JMP  = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd12;
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;
  function automatic logic is_mem_op(input logic [4:0] op);
    return op inside {OP_STO, OP_LD, OP_ADD, OP_SUB};
  endfunction
  function automatic logic is_alu_imm(input logic [4:0] op);
    return op inside {OP_LDI, OP_ADDI, OP_SUBI, OP_AND, OP_OR, OP_XOR};
  endfunction
endpackage

// File: rtl/bip_mc_cpu_if.sv
// bip_mc_cpu_if: instruction ROM port plus request/ready data RAM port of the BIP core
interface bip_mc_cpu_if #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR = 11,
  parameter int NB_DATA = 16
);
  logic [NB_ADDR-1:0] o_rom_addr;
  logic [NB_INSTRUCTION-1:0] i_rom_data;
  logic [NB_ADDR-1:0] o_ram_addr;
  logic [NB_DATA-1:0] o_ram_data;
  logic o_ram_wr_enable;
  logic o_ram_rd_enable;
  logic i_ram_ready;
  logic [NB_DATA-1:0] i_ram_data;
  modport master (
    output o_rom_addr, o_ram_addr, o_ram_data, o_ram_wr_enable, o_ram_rd_enable,
    input i_rom_data, i_ram_ready, i_ram_data
  );
  modport slave (
    input o_rom_addr, o_ram_addr, o_ram_data, o_ram_wr_enable, o_ram_rd_enable,
    output i_rom_data, i_ram_ready, i_ram_data
  );
endinterface

// File: rtl/bip_alu.sv
// bip_alu: accumulator datapath (add, sub, and, or, xor, pass-through of operand B)
module bip_alu import bip_pkg::*; #(
  parameter int NB_DATA = 16
) (
  input  logic [NB_DATA-1:0] acc_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [4:0]         opcode_i,
  output logic [NB_DATA-1:0] result_o
);
  // loads fall through to pass-through of B
  always_comb
    result_o = (opcode_i inside {OP_ADD, OP_ADDI}) ? acc_i + b_i :
               (opcode_i inside {OP_SUB, OP_SUBI}) ? acc_i - b_i :
               (opcode_i == OP_AND)                ? acc_i & b_i :
               (opcode_i == OP_OR)                 ? acc_i | b_i :
               (opcode_i == OP_XOR)                ? acc_i ^ b_i : b_i;
endmodule

// File: rtl/bip_mc_cpu.sv
// bip_mc_cpu: multi-cycle BIP core, handshake data RAM; BIP_PERF_COUNTERS_EN adds cycle/instruction counters
module bip_mc_cpu import bip_pkg::*; #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_OPCODE = 5,
  parameter int NB_OPERAND = NB_INSTRUCTION - NB_OPCODE,
  parameter int NB_ADDR = 11,
  parameter int NB_DATA = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  bip_mc_cpu_if.master       mem,
  output logic [NB_DATA-1:0] o_acc,
  output logic               o_halt
`ifdef BIP_PERF_COUNTERS_EN
  ,
  output logic [31:0]        o_cycle_count,
  output logic [31:0]        o_instr_count
`endif
);
  state_t state_q, state_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_INSTRUCTION-1:0] ir_q, ir_d;
  logic [NB_DATA-1:0] acc_q, acc_d;
  logic wr_q, wr_d, rd_q, rd_d;
  logic [4:0] opc;
  logic [NB_OPERAND-1:0] opd;
  logic [NB_DATA-1:0] ext_imm, alu_b, alu_y;
  logic [NB_ADDR-1:0] target;
  logic mem_op;
  assign opc = 5'(ir_q[NB_INSTRUCTION-1 -: NB_OPCODE]);
  assign opd = ir_q[NB_OPERAND-1:0];
  assign ext_imm = NB_DATA'($signed(opd));
  assign target = opd[NB_ADDR-1:0];
  assign mem_op = is_mem_op(opc);
  assign alu_b = (state_q == ST_MEM) ? mem.i_ram_data : ext_imm;
  assign mem.o_rom_addr = pc_q;
  assign mem.o_ram_addr = target;
  assign mem.o_ram_data = acc_q;
  assign mem.o_ram_wr_enable = wr_q;
  assign mem.o_ram_rd_enable = rd_q;
  assign o_acc = acc_q;
  assign o_halt = state_q == ST_HALT;
  bip_alu #(.NB_DATA(NB_DATA)) u_alu (.acc_i(acc_q), .b_i(alu_b), .opcode_i(opc), .result_o(alu_y));
  // architectural state; reset also aborts any pending memory wait
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state_q <= ST_FETCH;
      pc_q <= '0;
      ir_q <= '0;
      acc_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      acc_q <= acc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // fetch/execute/memory sequencing; enables are held until the ready cycle
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    acc_d = acc_q;
    wr_d = wr_q;
    rd_d = rd_q;
    case (state_q)
      ST_FETCH: begin
        ir_d = mem.i_rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (opc == OP_HLT) ? ST_HALT : mem_op ? ST_MEM : ST_FETCH;
        pc_d = (opc == OP_HLT || mem_op) ? pc_q :
               (opc == OP_JMP || (opc == OP_BEQ && acc_q == '0)) ? target : pc_q + 1'b1;
        acc_d = is_alu_imm(opc) ? alu_y : acc_q;
        wr_d = opc == OP_STO;
        rd_d = mem_op && opc != OP_STO;
      end
      ST_MEM:
        if (mem.i_ram_ready) begin
          state_d = ST_FETCH;
          pc_d = pc_q + 1'b1;
          acc_d = wr_q ? acc_q : alu_y;
          wr_d = 1'b0;
          rd_d = 1'b0;
        end
      default: ;
    endcase
  end
`ifdef BIP_PERF_COUNTERS_EN
  logic [31:0] cyc_q, ins_q;
  logic done;
  assign done = (state_q == ST_EXEC && !mem_op) || (state_q == ST_MEM && mem.i_ram_ready);
  assign o_cycle_count = cyc_q;
  assign o_instr_count = ins_q;
  // saturating counters, frozen while halted
  always_ff @(posedge i_clock)
    if (i_reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != ST_HALT && ~&cyc_q) cyc_q <= cyc_q + 1'b1;
      if (done && ~&ins_q) ins_q <= ins_q + 1'b1;
    end
`endif
endmodule

// File: tb/tb_bip_mc_cpu.sv
// tb_bip_mc_cpu: random and directed programs checked against an instruction-level model
module tb_bip_mc_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] acc;
  logic halt;
  logic [15:0] rom [2048];
  logic [15:0] ram [2048];
  logic [15:0] m_ram [2048];
  int m_pc;
  logic [15:0] m_acc;
  int n_vec = 0;
  int n_err = 0;
  int force_delay = -1;
  bit h;
  bip_mc_cpu_if #(.NB_INSTRUCTION(16), .NB_ADDR(11), .NB_DATA(16)) mem ();
`ifdef BIP_PERF_COUNTERS_EN
  logic [31:0] cyc, ins;
`endif
  bip_mc_cpu dut (
    .i_clock(clk),
    .i_reset(rst),
    .mem(mem.master),
    .o_acc(acc),
    .o_halt(halt)
`ifdef BIP_PERF_COUNTERS_EN
    ,
    .o_cycle_count(cyc),
    .o_instr_count(ins)
`endif
  );
  always #5 clk = ~clk;
  assign mem.i_rom_data = rom[mem.o_rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int opd);
    return {op[4:0], opd[10:0]};
  endfunction

  function automatic logic [31:0] en();
    return {30'd0, mem.o_ram_wr_enable, mem.o_ram_rd_enable};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      rom[i] = 16'd0;
      ram[i] = 16'($urandom);
      m_ram[i] = ram[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem.i_ram_ready = 1'b0;
    mem.i_ram_data = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0;
    m_acc = 16'd0;
    check("rst_pc", 32'(mem.o_rom_addr), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_en", en(), 32'd0);
    check("rst_addr", 32'(mem.o_ram_addr), 32'd0);
`ifdef BIP_PERF_COUNTERS_EN
    check("rst_cyc", cyc, 32'd0);
    check("rst_ins", ins, 32'd0);
`endif
  endtask

  task automatic step(output bit halted);
    logic [15:0] w, x, d;
    int op, a, dly;
    w = rom[m_pc];
    op = int'(w[15:11]);
    a = int'(w[10:0]);
    x = {{5{w[10]}}, w[10:0]};
    halted = 1'b0;
    mem.i_ram_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    check("exec_en", en(), 32'd0);
    mem.i_ram_ready = 1'($urandom_range(0, 1));
    if (op inside {1, 2, 4, 6}) begin
      @(posedge clk);
      @(negedge clk);
      dly = force_delay >= 0 ? force_delay : $urandom_range(0, 3);
      for (int i = 0; i <= dly; i++) begin
        check("mem_en", en(), op == 1 ? 32'd2 : 32'd1);
        check("mem_addr", 32'(mem.o_ram_addr), 32'(a));
        check("mem_acc", 32'(acc), 32'(m_acc));
        if (op == 1) check("sto_data", 32'(mem.o_ram_data), 32'(m_acc));
        if (i < dly) begin
          mem.i_ram_ready = 1'b0;
          mem.i_ram_data = 16'($urandom);
          @(posedge clk);
          @(negedge clk);
        end
      end
      mem.i_ram_ready = 1'b1;
      mem.i_ram_data = op == 1 ? 16'($urandom) : ram[mem.o_ram_addr];
      if (mem.o_ram_wr_enable) ram[mem.o_ram_addr] = mem.o_ram_data;
      @(posedge clk);
      @(negedge clk);
      mem.i_ram_ready = 1'b0;
      d = m_ram[a];
      case (op)
        1: m_ram[a] = m_acc;
        2: m_acc = d;
        4: m_acc = m_acc + d;
        default: m_acc = m_acc - d;
      endcase
      m_pc = (m_pc + 1) % 2048;
    end else begin
      @(posedge clk);
      @(negedge clk);
      case (op)
        0: halted = 1'b1;
        3: m_acc = x;
        5: m_acc = m_acc + x;
        7: m_acc = m_acc - x;
        8: m_acc = m_acc & x;
        9: m_acc = m_acc | x;
        10: m_acc = m_acc ^ x;
        default: ;
      endcase
      m_pc = op == 0 ? m_pc : (op == 11 || (op == 12 && m_acc == 16'd0)) ? a : (m_pc + 1) % 2048;
    end
    check("pc", 32'(mem.o_rom_addr), 32'(m_pc));
    check("acc", 32'(acc), 32'(m_acc));
    check("halt", 32'(halt), 32'(halted));
    check("done_en", en(), 32'd0);
  endtask

  task automatic check_frozen();
    repeat (3) begin
      mem.i_ram_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("hlt_halt", 32'(halt), 32'd1);
      check("hlt_pc", 32'(mem.o_rom_addr), 32'(m_pc));
      check("hlt_acc", 32'(acc), 32'(m_acc));
      check("hlt_en", en(), 32'd0);
    end
  endtask

  task automatic run(input int max_steps);
    bit hh;
    hh = 1'b0;
    do_reset();
    for (int s = 0; s < max_steps && !hh; s++) step(hh);
    if (hh) check_frozen();
  endtask

  initial begin
    clear_mem();
    rom[0] = enc(3, 5);
    rom[1] = enc(5, 2046);
    rom[2] = enc(0, 0);
    run(10);
    check("prog1_acc", 32'(acc), 32'd3);
    check("prog1_pc", 32'(mem.o_rom_addr), 32'd2);
`ifdef BIP_PERF_COUNTERS_EN
    check("prog1_cyc", cyc, 32'd6);
    check("prog1_ins", ins, 32'd3);
`endif
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      rom[0] = enc(3, 2047);
      rom[1] = enc(1, 10);
      rom[2] = enc(2, 10);
      rom[3] = enc(0, 0);
      force_delay = k == 0 ? 0 : 2;
      run(10);
      check("sto_ram", 32'(ram[10]), 32'hFFFF);
      check("ld_acc", 32'(acc), 32'hFFFF);
    end
    force_delay = -1;
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      rom[0] = enc(3, k);
      rom[1] = enc(12, 5);
      rom[2] = enc(3, 1);
      rom[3] = enc(0, 0);
      rom[4] = enc(0, 0);
      rom[5] = enc(3, 9);
      rom[6] = enc(0, 0);
      run(10);
      check("beq_acc", 32'(acc), k == 0 ? 32'd9 : 32'd1);
    end
    clear_mem();
    rom[0] = enc(3, 1023);
    for (int i = 1; i <= 70; i++) rom[i] = enc(5, 1023);
    rom[71] = enc(0, 0);
    run(100);
    check("wrap_acc", 32'(acc), 32'd7097);
    clear_mem();
    rom[0] = enc(11, 2047);
    rom[2047] = enc(13, 0);
    run(2);
    check("pc_wrap", 32'(mem.o_rom_addr), 32'd0);
    clear_mem();
    rom[0] = enc(3, 7);
    rom[1] = enc(2, 5);
    do_reset();
    step(h);
    mem.i_ram_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("wait_rd", en(), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_en", en(), 32'd0);
    check("mrst_pc", 32'(mem.o_rom_addr), 32'd0);
    check("mrst_acc", 32'(acc), 32'd0);
    check("mrst_halt", 32'(halt), 32'd0);
`ifdef BIP_PERF_COUNTERS_EN
    check("mrst_cyc", cyc, 32'd0);
    check("mrst_ins", ins, 32'd0);
`endif
    m_pc = 0;
    m_acc = 16'd0;
    step(h);
    check("mrst_fetch", 32'(acc), 32'd7);
    repeat (30) begin
      int op;
      clear_mem();
      for (int i = 0; i < 64; i++) begin
        op = $urandom_range(0, 15);
        if (op == 0 && $urandom_range(0, 3) != 0) op = 13;
        rom[i] = enc(op, (op == 11 || op == 12) ? $urandom_range(0, 63) :
                         (op inside {1, 2, 4, 6}) ? $urandom_range(0, 15) : $urandom_range(0, 2047));
      end
      run(80);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
